// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: tracks the
// destination and remaining Tnew of each in-flight instruction, plus HI/LO busy time.
module hazard_ctrl #(
   parameter int RA_W        = 5,
   parameter int T_W         = 3,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RA_W-1:0] d_rs,
   input  logic [RA_W-1:0] d_rt,
   input  logic [T_W-1:0]  d_rs_tuse,
   input  logic [T_W-1:0]  d_rt_tuse,
   input  logic [T_W-1:0]  d_tnew,
   input  logic [RA_W-1:0] d_dst,
   input  logic            d_md_start,
   input  logic            d_md_div,
   input  logic            d_md_use,
   output logic            stall,
   output logic [1:0]      d_fwd_rs,
   output logic [1:0]      d_fwd_rt,
   output logic [1:0]      e_fwd_rs,
   output logic [1:0]      e_fwd_rt,
   output logic [RA_W-1:0] e_dst,
   output logic [RA_W-1:0] m_dst,
   output logic [RA_W-1:0] w_dst,
   output logic            md_busy
);

   logic [T_W-1:0]   e_tnew, m_tnew;
   logic [RA_W-1:0]  e_rs, e_rt;
   logic             e_md;
   logic [CNT_W-1:0] md_cnt;
   logic             rs_haz, rt_haz, md_haz;

   // Operand hazard: a producer in E or M will not have its result ready in time.
   function automatic logic op_haz(input logic [RA_W-1:0] a, input logic [T_W-1:0] tu,
                                   input logic [RA_W-1:0] ed, input logic [T_W-1:0] et,
                                   input logic [RA_W-1:0] md, input logic [T_W-1:0] mt);
      return (a != '0) && (tu != '1) &&
             (((ed == a) && (et > tu)) || ((md == a) && (mt > tu)));
   endfunction

   // Nearest matching stage wins; a not-yet-ready nearest producer yields 0.
   function automatic logic [1:0] d_sel(input logic [RA_W-1:0] a,
                                        input logic [RA_W-1:0] ed, input logic [T_W-1:0] et,
                                        input logic [RA_W-1:0] md, input logic [T_W-1:0] mt,
                                        input logic [RA_W-1:0] wd);
      if (a == '0)         return 2'd0;
      else if (ed == a)    return (et == '0) ? 2'd1 : 2'd0;
      else if (md == a)    return (mt == '0) ? 2'd2 : 2'd0;
      else if (wd == a)    return 2'd3;
      else                 return 2'd0;
   endfunction

   function automatic logic [1:0] e_sel(input logic [RA_W-1:0] a,
                                        input logic [RA_W-1:0] md, input logic [T_W-1:0] mt,
                                        input logic [RA_W-1:0] wd);
      if (a == '0)         return 2'd0;
      else if (md == a)    return (mt == '0) ? 2'd2 : 2'd0;
      else if (wd == a)    return 2'd3;
      else                 return 2'd0;
   endfunction

   always_comb begin
      rs_haz   = op_haz(d_rs, d_rs_tuse, e_dst, e_tnew, m_dst, m_tnew);
      rt_haz   = op_haz(d_rt, d_rt_tuse, e_dst, e_tnew, m_dst, m_tnew);
      md_haz   = d_md_use && ((md_cnt != '0) || e_md);
      stall    = rs_haz || rt_haz || md_haz;
      md_busy  = (md_cnt != '0);
      d_fwd_rs = d_sel(d_rs, e_dst, e_tnew, m_dst, m_tnew, w_dst);
      d_fwd_rt = d_sel(d_rt, e_dst, e_tnew, m_dst, m_tnew, w_dst);
      e_fwd_rs = e_sel(e_rs, m_dst, m_tnew, w_dst);
      e_fwd_rt = e_sel(e_rt, m_dst, m_tnew, w_dst);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_dst  <= '0;
         e_tnew <= '0;
         e_rs   <= '0;
         e_rt   <= '0;
         e_md   <= 1'b0;
         m_dst  <= '0;
         m_tnew <= '0;
         w_dst  <= '0;
         md_cnt <= '0;
      end else begin
         w_dst  <= m_dst;
         m_dst  <= e_dst;
         m_tnew <= (e_tnew != '0) ? e_tnew - 1'b1 : '0;
         if (stall) begin
            e_dst  <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            e_md   <= 1'b0;
         end else begin
            e_dst  <= d_dst;
            e_tnew <= d_tnew;
            e_rs   <= d_rs;
            e_rt   <= d_rt;
            e_md   <= d_md_start;
         end
         if (d_md_start && !stall)
            md_cnt <= d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
      end
   end

endmodule
